// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Two-requester arbiter (CPU and vector unit) in front of a single-port SRAM.
// Each access takes three cycles: IDLE samples and registers the winner's
// request, ACC drives the SRAM command, and RESP returns the SRAM read data
// together with a one-cycle ready pulse to the winner.
//
// The vector unit can hold ownership across a burst with vec_lock.
// LOCK_MAX bounds how many locked vector grants may pass in a row before a
// waiting CPU is given one slot.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// unlocked requests round-robin. Without it, the CPU always wins such requests.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb        CPU request (wstrb == 0 means read)
//   cpu_ready, cpu_rdata              CPU completion pulse and read data
//   vec_valid/addr/wdata/wstrb        vector-unit request
//   vec_lock                          vector unit asks to keep ownership
//   vec_ready, vec_rdata              vector completion pulse and read data
//   sram_en/we/addr/wdata             SRAM command, driven only in ACC
//   sram_rdata                        SRAM read data, one cycle after command
//   grant_vec                         current/last grant belongs to vector unit
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_valid,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_ready,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    input  logic                    vec_valid,
    input  logic [ADDR_WIDTH-1:0]   vec_addr,
    input  logic [DATA_WIDTH-1:0]   vec_wdata,
    input  logic [DATA_WIDTH/8-1:0] vec_wstrb,
    input  logic                    vec_lock,
    output logic                    vec_ready,
    output logic [DATA_WIDTH-1:0]   vec_rdata,
    output logic                    sram_en,
    output logic [DATA_WIDTH/8-1:0] sram_we,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    output logic                    grant_vec
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RESP
    } state_t;

    state_t                  state, state_nxt;
    logic                    grant_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_nxt;
    logic                    lock_q, lock_nxt;
    logic [3:0]              lock_count, lock_count_nxt;

    logic                    lock_active;
    logic                    lock_override;
    logic                    cpu_elig;
    logic                    vec_elig;
    logic                    pick_vec;

    // Eligibility. A lock only holds while vec_lock is still asserted; once
    // the locked run reaches LOCK_MAX a waiting CPU takes exactly one slot.
    always_comb begin
        lock_active   = lock_q && vec_lock;
        lock_override = lock_active && cpu_valid && (lock_count == LOCK_LIMIT);
        cpu_elig      = lock_active ? lock_override : cpu_valid;
        vec_elig      = vec_valid && !lock_override;
        if (cpu_elig && vec_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_vec = !grant_vec;
`else
            pick_vec = 1'b0;
`endif
        end else begin
            pick_vec = vec_elig;
        end
    end

    // State, registered request copy, lock bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_vec  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            lock_q     <= 1'b0;
            lock_count <= 4'd0;
        end else begin
            state      <= state_nxt;
            grant_vec  <= grant_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            wstrb_q    <= wstrb_nxt;
            lock_q     <= lock_nxt;
            lock_count <= lock_count_nxt;
        end
    end

    // Next-state and output decode. The counter stops at LOCK_MAX so the
    // equality test that releases a starved CPU can never be skipped past.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_vec;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        wstrb_nxt      = wstrb_q;
        lock_nxt       = lock_q;
        lock_count_nxt = lock_count;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        vec_ready      = 1'b0;
        vec_rdata      = '0;
        sram_en        = 1'b0;
        sram_we        = '0;
        sram_addr      = '0;
        sram_wdata     = '0;

        case (state)
            IDLE: begin
                if (!vec_lock) begin
                    lock_nxt       = 1'b0;
                    lock_count_nxt = 4'd0;
                end
                if (cpu_elig || vec_elig) begin
                    state_nxt = ACC;
                    grant_nxt = pick_vec;
                    addr_nxt  = pick_vec ? vec_addr  : cpu_addr;
                    wdata_nxt = pick_vec ? vec_wdata : cpu_wdata;
                    wstrb_nxt = pick_vec ? vec_wstrb : cpu_wstrb;
                    if (!pick_vec) begin
                        lock_count_nxt = 4'd0;
                    end else if (vec_lock && (lock_count < LOCK_LIMIT)) begin
                        lock_count_nxt = lock_count + 4'd1;
                    end
                end
            end
            ACC: begin
                state_nxt  = RESP;
                sram_en    = 1'b1;
                sram_we    = wstrb_q;
                sram_addr  = addr_q;
                sram_wdata = wdata_q;
            end
            RESP: begin
                state_nxt = IDLE;
                if (grant_vec) begin
                    vec_ready = 1'b1;
                    vec_rdata = sram_rdata;
                    if (vec_lock) begin
                        lock_nxt = 1'b1;
                    end
                end else begin
                    cpu_ready = 1'b1;
                    cpu_rdata = sram_rdata;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// --------------
// Self-checking bench for mem_arbiter. A behavioural SRAM answers the DUT's
// commands. A transaction-level reference model predicts each slot's winner
// from the arbitration rules and predicts read data from its own memory image.
// Both models follow MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

    localparam int LM = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, vec_valid, vec_lock;
    logic [31:0] cpu_addr, cpu_wdata, vec_addr, vec_wdata;
    logic [3:0]  cpu_wstrb, vec_wstrb;
    logic        cpu_ready, vec_ready, sram_en, grant_vec;
    logic [31:0] cpu_rdata, vec_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_we;
    logic [31:0] sram_rdata = '0;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_lock, m_last_vec;
    int          m_count;
    logic [31:0] ref_mem [64];
    logic [63:0] ref_written = '0;
    bit          cpu_pend, vec_pend;

    // Behavioural SRAM.
    logic [31:0] sram_mem [64];
    logic [63:0] sram_written = '0;
    logic [5:0]  sram_idx;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .vec_wstrb(vec_wstrb), .vec_lock(vec_lock), .vec_ready(vec_ready),
        .vec_rdata(vec_rdata), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .grant_vec(grant_vec)
    );

    function automatic logic [31:0] seed_word(logic [5:0] i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    assign sram_idx = sram_addr[7:2];

    // Unwritten words return a seed pattern, so reads are meaningful from the start.
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_written[sram_idx] ? sram_mem[sram_idx] : seed_word(sram_idx);
            if (sram_we != 4'h0) begin
                sram_mem[sram_idx] <= merge_bytes(sram_written[sram_idx] ? sram_mem[sram_idx]
                                                  : seed_word(sram_idx), sram_wdata, sram_we);
                sram_written[sram_idx] <= 1'b1;
            end
        end
    end

    // Counts every comparison and reports mismatches on one line.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic doReset(input bit check_it);
        reset = 1'b1;
        cpu_valid = 1'b0; vec_valid = 1'b0; vec_lock = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        vec_addr = '0; vec_wdata = '0; vec_wstrb = '0;
        cpu_pend = 1'b0; vec_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (check_it) begin
            checkOutput("rst_sram_en", 64'(sram_en), 0);
            checkOutput("rst_sram_we", 64'(sram_we), 0);
            checkOutput("rst_sram_addr", 64'(sram_addr), 0);
            checkOutput("rst_sram_wdata", 64'(sram_wdata), 0);
            checkOutput("rst_ready", 64'({cpu_ready, vec_ready}), 0);
            checkOutput("rst_grant_vec", 64'(grant_vec), 0);
        end
        reset = 1'b0;
        m_lock = 1'b0; m_count = 0; m_last_vec = 1'b0;
    endtask

    task automatic reqCpu(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!cpu_pend) begin
            cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_pend = 1'b1;
        end
    endtask

    task automatic reqVec(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!vec_pend) begin
            vec_valid = 1'b1; vec_addr = a; vec_wdata = d; vec_wstrb = s; vec_pend = 1'b1;
        end
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 99) < 60)
            reqCpu(32'($urandom_range(0, 63)) << 2, $urandom,
                   $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)));
        if ($urandom_range(0, 99) < 60)
            reqVec(32'($urandom_range(0, 63)) << 2, $urandom,
                   $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)));
        vec_lock = ($urandom_range(0, 99) < 65);
    endtask

    // One arbitration slot: predicts the winner and checks ACC, RESP and the
    // return to IDLE. It reports 0 for an idle slot, 1 for CPU, 2 for vector.
    task automatic runSlot(input bit allow_drop, output int win);
        int          exp_win;
        bit          cv, vv, vl;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [3:0]  e_strb;
        logic [5:0]  idx;
        cv = cpu_valid; vv = vec_valid; vl = vec_lock;
        if (!vl) begin m_lock = 1'b0; m_count = 0; end
        if (m_lock) exp_win = (cv && m_count == LM) ? 1 : (vv ? 2 : 0);
        else if (cv && vv) exp_win = (RR_EN && !m_last_vec) ? 2 : 1;
        else exp_win = cv ? 1 : (vv ? 2 : 0);
        win = exp_win;
        if (exp_win == 0) begin
            @(posedge clk); #1;
            checkOutput("idle_sram_en", 64'(sram_en), 0);
            checkOutput("idle_ready", 64'({cpu_ready, vec_ready}), 0);
            return;
        end
        e_addr  = (exp_win == 1) ? cpu_addr  : vec_addr;
        e_wdata = (exp_win == 1) ? cpu_wdata : vec_wdata;
        e_strb  = (exp_win == 1) ? cpu_wstrb : vec_wstrb;
        idx  = e_addr[7:2];
        e_rd = ref_written[idx] ? ref_mem[idx] : seed_word(idx);
        if (e_strb != 4'h0) begin
            ref_mem[idx] = merge_bytes(e_rd, e_wdata, e_strb);
            ref_written[idx] = 1'b1;
        end
        if (exp_win == 1) m_count = 0;
        else if (vl) begin m_count = (m_count < LM) ? m_count + 1 : m_count; m_lock = 1'b1; end
        m_last_vec = (exp_win == 2);

        @(posedge clk); #1;
        checkOutput("acc_sram_en", 64'(sram_en), 1);
        checkOutput("acc_sram_addr", 64'(sram_addr), 64'(e_addr));
        checkOutput("acc_sram_we", 64'(sram_we), 64'(e_strb));
        checkOutput("acc_sram_wdata", 64'(sram_wdata), 64'(e_wdata));
        checkOutput("acc_grant_vec", 64'(grant_vec), 64'(exp_win == 2));
        checkOutput("acc_ready", 64'({cpu_ready, vec_ready}), 0);
        checkOutput("acc_rdata", {cpu_rdata, vec_rdata}, 0);
        // The winner may withdraw and scramble its request once it has been sampled.
        if (allow_drop && $urandom_range(0, 3) == 0) begin
            if (exp_win == 1) begin
                cpu_valid = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom); cpu_pend = 1'b0;
            end else begin
                vec_valid = 1'b0; vec_addr = $urandom; vec_wdata = $urandom; vec_wstrb = 4'($urandom); vec_pend = 1'b0;
            end
        end

        @(posedge clk); #1;
        checkOutput("resp_ready", 64'({cpu_ready, vec_ready}), (exp_win == 1) ? 64'h2 : 64'h1);
        if (exp_win == 1) begin
            checkOutput("resp_cpu_rdata", 64'(cpu_rdata), 64'((e_strb == 0) ? e_rd : sram_rdata));
            checkOutput("resp_vec_rdata", 64'(vec_rdata), 0);
            cpu_valid = 1'b0; cpu_pend = 1'b0;
        end else begin
            checkOutput("resp_vec_rdata", 64'(vec_rdata), 64'((e_strb == 0) ? e_rd : sram_rdata));
            checkOutput("resp_cpu_rdata", 64'(cpu_rdata), 0);
            vec_valid = 1'b0; vec_pend = 1'b0;
        end
        checkOutput("resp_sram", 64'({sram_en, sram_we}), 0);

        @(posedge clk); #1;
        checkOutput("back_idle", 64'({cpu_ready, vec_ready, sram_en}), 0);
    endtask

    initial begin
        int w;
        doReset(1'b1);

        // CPU writes DEADBEEF to 0x40, reads it back, then a partial write to 0x80.
        reqCpu(32'h40, 32'hDEADBEEF, 4'hF);
        runSlot(1'b0, w);
        reqCpu(32'h40, 32'h0, 4'h0);
        runSlot(1'b0, w);
        checkOutput("cpu_read_winner", 64'(w), 1);
        reqCpu(32'h80, 32'h12345678, 4'h3);
        runSlot(1'b0, w);

        // Both requesters valid every slot with no lock.
        doReset(1'b0);
        for (int i = 0; i < 4; i++) begin
            reqCpu(32'(i) * 4, $urandom, 4'h0);
            reqVec(32'h20 + 32'(i) * 4, $urandom, 4'h0);
            runSlot(1'b0, w);
            checkOutput("contend_seq", 64'(w), (RR_EN && (i % 2 == 0)) ? 64'd2 : 64'd1);
        end
        runSlot(1'b0, w);
        checkOutput("contend_cpu_gone", 64'(w), 2);

        // A locked vector burst lets the CPU in once after LOCK_MAX grants.
        doReset(1'b0);
        vec_lock = 1'b1;
        reqVec(32'h10, $urandom, 4'h0);
        runSlot(1'b0, w);
        checkOutput("lock_first", 64'(w), 2);
        for (int k = 0; k < 9; k++) begin
            reqCpu(32'h44, $urandom, 4'h0);
            reqVec(32'h10 + 32'(k) * 4, $urandom, 4'h0);
            runSlot(1'b0, w);
            checkOutput("lock_seq", 64'(w), (k == 7) ? 64'd1 : 64'd2);
        end

        // Reset during the ACC cycle of a vector read abandons it.
        doReset(1'b0);
        reqVec(32'h30, 32'h0, 4'h0);
        @(posedge clk); #1;
        checkOutput("abort_acc_en", 64'(sram_en), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vec_valid = 1'b0; vec_pend = 1'b0;
        m_lock = 1'b0; m_count = 0; m_last_vec = 1'b0;
        checkOutput("abort_ready", 64'({cpu_ready, vec_ready}), 0);
        checkOutput("abort_sram", 64'({sram_en, sram_we, sram_addr, sram_wdata}), 0);
        checkOutput("abort_grant_vec", 64'(grant_vec), 0);
        @(posedge clk); #1;
        checkOutput("abort_no_late_ready", 64'({cpu_ready, vec_ready}), 0);
        reqCpu(32'h40, 32'h0, 4'h0);
        runSlot(1'b0, w);
        checkOutput("abort_next_cpu", 64'(w), 1);

        // Random traffic with locks, drops and contention.
        doReset(1'b0);
        repeat (250) begin
            applyStimulus();
            runSlot(1'b1, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
